// File: rtl/wb_sram_slave.sv
// Wishbone B4 classic SRAM responder with programmable wait states and byte-masked writes.
// Optional read-only low region enabled by defining WB_SRAM_RO_REGION_EN.
module wb_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned RO_WORDS    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = 4;
`ifdef WB_SRAM_RO_REGION_EN
  localparam bit RO_EN = 1'b1;
`else
  localparam bit RO_EN = 1'b0;
`endif
  localparam int unsigned RO_LIMIT = RO_EN ? RO_WORDS : 0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   adr_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;
  logic          we_q;
  logic          resp_err_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          req_c;
  logic [31:0]   cur_adr_c;
  logic [31:0]   cur_dat_c;
  logic [3:0]    cur_sel_c;
  logic          cur_we_c;
  logic [29:0]   word_off_c;
  logic          hit_c;
  logic [AW-1:0] idx_c;
  logic          ro_c;
  logic          enter_resp_c;
  logic          wr_en_c;

  assign req_c = wb_cyc_i & wb_stb_i;

  // In IDLE the live bus is decoded so a zero-wait request commits on its sampling edge.
  always_comb begin
    cur_adr_c = adr_q;
    cur_dat_c = dat_q;
    cur_sel_c = sel_q;
    cur_we_c  = we_q;
    if (state == IDLE) begin
      cur_adr_c = wb_adr_i;
      cur_dat_c = wb_dat_i;
      cur_sel_c = wb_sel_i;
      cur_we_c  = wb_we_i;
    end
  end

  assign word_off_c   = 30'((cur_adr_c - BASE_ADDR) >> 2);
  assign hit_c        = (cur_adr_c >= BASE_ADDR) && (word_off_c < 30'(DEPTH_WORDS));
  assign idx_c        = word_off_c[AW-1:0];
  assign ro_c         = cur_we_c && (32'(idx_c) < RO_LIMIT);
  assign enter_resp_c = ((state == IDLE) && req_c && (WAIT_STATES == 0)) ||
                        ((state == WAIT) && wb_cyc_i && (cnt == CW'(1)));
  assign wr_en_c      = enter_resp_c && cur_we_c && hit_c && !ro_c;

  // Storage array: byte-masked write, never reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_sel_c[b]) mem[idx_c][8*b +: 8] <= cur_dat_c[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      resp_err_q <= 1'b0;
      wb_dat_o   <= '0;
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      if (enter_resp_c) begin
        if (hit_c && !cur_we_c) wb_dat_o <= mem[idx_c];
        resp_err_q <= !hit_c || ro_c;
      end
      case (state)
        IDLE: begin
          if (req_c) begin
            adr_q <= wb_adr_i;
            dat_q <= wb_dat_i;
            sel_q <= wb_sel_i;
            we_q  <= wb_we_i;
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              cnt   <= CW'(WAIT_STATES);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // Initiator abandoning the cycle drops the transfer silently.
          if (!wb_cyc_i) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= RESP;
          end
        end
        RESP: begin
          wb_ack_o <= !resp_err_q;
          wb_err_o <= resp_err_q;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_sram_slave.md
Name: wb_sram_slave

Overview:
- Wishbone B4 classic (non-pipelined) responder: a single-port word-organised SRAM on the SoC interconnect, answering the core/debug Wishbone controller.
- Decodes its address window, applies programmable wait states, commits byte-masked writes and returns full read words.
- Signals ack or err as a registered one-cycle pulse.
- Byte/halfword alignment of read data is done by the initiator; this block always returns the whole word.

Parameters:
- BASE_ADDR, 32'h2000_0000, byte address of word 0; must be 4-byte aligned.
- DEPTH_WORDS, 1024, number of 32-bit words (power of two, >= 2).
- WAIT_STATES, 0, extra cycles inserted before the response (0..15).
- RO_WORDS, 0, words from index 0 that are read-only (used only with WB_SRAM_RO_REGION_EN).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- wb_adr_i  input  32  byte address
- wb_dat_i  input  32  write data
- wb_sel_i  input  4  byte enables; bit n covers data[8n+7:8n]
- wb_we_i  input  1  1 = write, 0 = read
- wb_cyc_i  input  1  bus cycle valid
- wb_stb_i  input  1  strobe
- wb_dat_o  output  32  read data, valid while wb_ack_o = 1
- wb_ack_o  output  1  transfer done, one-cycle pulse
- wb_err_o  output  1  transfer failed, one-cycle pulse

Behaviour:
- Reset, asynchronous: FSM to IDLE, wait counter = 0, wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 0. SRAM contents are not reset.
- Request: cyc & stb sampled high on a rising edge while in IDLE. stb without cyc is ignored.
- The request is latched in IDLE: address, data, sel, we.
- Decode:
  - hit = BASE_ADDR <= adr < BASE_ADDR + 4*DEPTH_WORDS.
  - index = (adr - BASE_ADDR) >> 2.
  - adr[1:0] is ignored.
- States:
  - IDLE: on request with WAIT_STATES = 0, go to RESP. With WAIT_STATES > 0, load the counter with WAIT_STATES and go to WAIT.
  - WAIT: decrement the counter each cycle; go to RESP on the edge where the counter reaches 0. If cyc drops in WAIT, abort: go to IDLE, no write, no ack, no err.
  - RESP: drive ack (hit) or err (miss) for exactly one cycle, then go to IDLE unconditionally. cyc/stb during the RESP cycle belong to the current transfer and are not a new request.
- Commit: on the edge that enters RESP.
  - Write hit: update only the bytes with sel = 1. sel = 4'b0000 still acks and changes nothing.
  - Read hit: wb_dat_o <= mem[index].
  - Miss: no memory access; wb_dat_o keeps its previous value.
- Latency: request sampled on edge N → ack/err high during the cycle after edge N+1+WAIT_STATES.
- Back-to-back throughput: one transfer per 2+WAIT_STATES cycles. A request still held high in the cycle after RESP is accepted as a new transfer.
- Outputs: wb_ack_o and wb_err_o are never both 1, and both are registered (no combinational path from the inputs).
- Reset during WAIT or RESP: the transfer is dropped with no write and the outputs go low immediately.

Optional Feature:
- Macro: WB_SRAM_RO_REGION_EN.
- Defined:
  - Writes hitting index < RO_WORDS: no memory update; respond with err instead of ack, same latency.
  - Reads in that region behave normally.
  - The region is loadable only through a hierarchical initialisation path.
- Undefined: RO_WORDS is ignored and every word is writable.

Test Plan:
- WAIT_STATES=0, write 0xDEADBEEF to 0x2000_0010 with sel=4'hF, then read 0x2000_0010 → ack 2 cycles after each request is sampled; read returns 0xDEADBEEF.
- Byte mask: preload 0x1122_3344, write 0xAABB_CCDD with sel=4'b0101 → read returns 0x11BB_33DD.
- WAIT_STATES=3, read 0x2000_0FFC (last word) → ack exactly 5 cycles after the request is sampled.
- Out of range: read 0x2000_1000, then write 0x1FFF_FFFC → err pulse for 1 cycle each, ack stays 0, wb_dat_o unchanged, no word modified.
- WAIT_STATES=3: drop cyc in the second wait cycle of a write → no ack/err; memory unchanged. Assert rst mid-WAIT in a separate run → ack/err/wb_dat_o = 0 at once; FSM back in IDLE.
- WB_SRAM_RO_REGION_EN with RO_WORDS=4: write 0x2000_0008 → err and word unchanged. Write 0x2000_0010 → ack and word updated.
